otp_entry: RTL and testbench
============================

Name: otp_entry

Overview:
- User-side OTP digit-entry block; the input counterpart of the OTP display path.
- Samples raw switch/button inputs, builds the 4-digit BCD user OTP (16 bits) one digit at a time, and supports digit delete and full clear.
- Presents the assembled word with a one-cycle valid strobe to the authentication FSM, then holds the entry locked until that FSM acknowledges.
- user_otp feeds both the comparator and the display path.

Parameters:
- DIGITS, 4, number of BCD digits per OTP; user_otp width is 4*DIGITS.
- SYNC_STAGES, 2, synchronizer flops on each raw button/switch input (minimum 2).

Ports:
- clk_out_disp2  input  1  block clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- din  input  4  raw digit switches (BCD value to load).
- btn_load  input  1  raw button: append din as a new digit.
- btn_del  input  1  raw button: remove the last entered digit.
- btn_clr  input  1  raw button: clear the whole entry.
- btn_submit  input  1  raw button: submit the entry.
- busy  input  1  authentication FSM busy; synchronous to clk_out_disp2.
- lock  input  1  lockout active; synchronous to clk_out_disp2.
- otp_ack  input  1  one-cycle result-taken pulse; synchronous to clk_out_disp2.
- user_otp  output  16  entered digits; digit 0 (newest) in [3:0].
- digit_cnt  output  3  number of digits entered, 0..DIGITS.
- otp_valid  output  1  one-cycle submit strobe.
- entry_full  output  1  high when digit_cnt == DIGITS.
- err  output  1  one-cycle pulse on a rejected action.

Behaviour:
- Reset (async, rstn low): user_otp=0, digit_cnt=0, otp_valid=0, entry_full=0, err=0, state IDLE, all synchronizer and edge flops 0.
- Input conditioning:
  - din and each btn_* pass through SYNC_STAGES flops.
  - A press is a rising edge of the synchronized button: the last sync flop is 1 and the previous-sample flop is 0.
  - A button that goes high before edge k produces its action on registered outputs at edge k+SYNC_STAGES (k+2 by default).
  - Holding a button yields exactly one action.
- Priority when several edges occur in the same cycle: btn_clr > btn_del > btn_submit > btn_load. Only the highest-priority edge acts; the others are dropped.
- States: IDLE (cnt 0), ENTRY (0 < cnt < DIGITS), FULL (cnt == DIGITS), SUBMIT, WAIT.
- load, in IDLE/ENTRY:
  - If synchronized din <= 9: user_otp <= {user_otp[11:0], din}; cnt+1; go to ENTRY, or FULL when cnt reaches DIGITS.
  - If din > 9: err pulse, no change.
  - In FULL: err pulse, no change.
- del:
  - If cnt > 0: user_otp <= {4'h0, user_otp[15:4]}; cnt-1; state follows the new cnt.
  - If cnt == 0: no-op, no err.
- clr: user_otp=0, cnt=0, state IDLE, from any state except WAIT.
- submit:
  - In FULL with busy=0: go to SUBMIT.
  - In FULL with busy=1: err, stay FULL.
  - In IDLE/ENTRY: err, no change.
- SUBMIT: otp_valid=1 for exactly this one cycle; user_otp stable; next state WAIT.
- WAIT:
  - All buttons are ignored, including clr; no err pulses.
  - On otp_ack=1: user_otp=0, cnt=0, state IDLE on the next edge.
  - otp_ack in any other state is ignored.
- lock=1, any state: user_otp=0, cnt=0, state IDLE, otp_valid=0 on the next edge. All button edges are ignored while lock=1. Edges already in the synchronizer when lock falls act normally.
- Outputs:
  - entry_full is registered and is 1 exactly when cnt == DIGITS (FULL, SUBMIT, WAIT).
  - otp_valid and err are registered and never high in the same cycle.
- cnt never exceeds DIGITS and never wraps below 0.

Test Plan:
- Load digits 1, 2, 3, 4 (din then btn_load each) -> user_otp=16'h1234, digit_cnt=4, entry_full=1; each update lands 2 edges after its button rises.
- From 16'h1234, btn_del -> user_otp=16'h0123, cnt=3. Load 9 -> 16'h1239, cnt=4. Load 5 while FULL -> err pulse, value unchanged.
- din=4'hB with btn_load -> err pulse, user_otp unchanged. btn_submit with cnt=2 -> err, no otp_valid.
- FULL with 16'h4321, busy=0, btn_submit -> otp_valid high one cycle with user_otp=16'h4321. In WAIT, btn_clr/btn_load are ignored. otp_ack -> user_otp=0, cnt=0 next edge.
- Simultaneous btn_clr and btn_load edges -> cleared, no digit appended. A button held 10 cycles -> exactly one digit loaded.
- lock=1 mid-entry (cnt=3) -> cleared next edge; presses during lock have no effect. rstn pulsed low in WAIT -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/otp_entry.sv
// otp_entry: user-side OTP digit entry.
//
// Conditions the raw digit switches and buttons through synchronizers, turns
// button rising edges into single actions, and assembles a DIGITS-long BCD word
// one digit at a time (newest digit in the low nibble). A completed entry is
// presented to the authentication FSM with a one-cycle otp_valid strobe. After
// that, the entry stays locked until otp_ack arrives.
//
// Ports:
//   clk_out_disp2  block clock, rising edge
//   rstn           asynchronous active-low reset
//   din            raw BCD digit switches
//   btn_load       raw button: append din as the newest digit
//   btn_del        raw button: drop the newest digit
//   btn_clr        raw button: clear the entry
//   btn_submit     raw button: submit a full entry
//   busy           authentication FSM busy (synchronous)
//   lock           lockout active (synchronous), clears and blocks entry
//   otp_ack        result-taken pulse (synchronous), releases a submitted entry
//   user_otp       entered digits, digit 0 (newest) in [3:0]
//   digit_cnt      number of digits entered, 0..DIGITS
//   otp_valid      one-cycle submit strobe
//   entry_full     digit_cnt == DIGITS
//   err            one-cycle pulse on a rejected action
module otp_entry #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_out_disp2,
  input  logic                  rstn,
  input  logic [3:0]            din,
  input  logic                  btn_load,
  input  logic                  btn_del,
  input  logic                  btn_clr,
  input  logic                  btn_submit,
  input  logic                  busy,
  input  logic                  lock,
  input  logic                  otp_ack,
  output logic [4*DIGITS-1:0]   user_otp,
  output logic [2:0]            digit_cnt,
  output logic                  otp_valid,
  output logic                  entry_full,
  output logic                  err
);

  localparam int unsigned W       = 4 * DIGITS;
  localparam logic [2:0]  CntFull = 3'(DIGITS);

  typedef enum logic [2:0] {StIdle, StEntry, StFull, StSubmit, StWait} state_e;

  // Button vector bit order: {clr, del, submit, load}.
  logic [3:0] btn_raw;
  assign btn_raw = {btn_clr, btn_del, btn_submit, btn_load};

  logic [3:0] btn_sync_q [SYNC_STAGES];
  logic [3:0] btn_sync_d [SYNC_STAGES];
  logic [3:0] din_sync_q [SYNC_STAGES];
  logic [3:0] din_sync_d [SYNC_STAGES];
  logic [3:0] btn_prev_q, btn_prev_d;

  state_e        state_q, state_d;
  logic [W-1:0]  otp_q, otp_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          err_q, err_d;

  logic [3:0]    btn_s, din_s, press;
  logic          press_clr, press_del, press_submit, press_load;
  logic [2:0]    cnt_dec, cnt_inc;

  always_comb begin
    btn_sync_d[0] = btn_raw;
    din_sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      btn_sync_d[i] = btn_sync_q[i-1];
      din_sync_d[i] = din_sync_q[i-1];
    end
  end

  assign btn_s      = btn_sync_q[SYNC_STAGES-1];
  assign din_s      = din_sync_q[SYNC_STAGES-1];
  assign btn_prev_d = btn_s;
  // Rising edge of the synchronized button; holding it yields one press.
  assign press        = btn_s & ~btn_prev_q;
  assign press_clr    = press[3];
  assign press_del    = press[2];
  assign press_submit = press[1];
  assign press_load   = press[0];
  assign cnt_dec      = cnt_q - 3'd1;
  assign cnt_inc      = cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    otp_d   = otp_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (lock) begin
      // Presses seen during lock are consumed by the edge flop and dropped.
      state_d = StIdle;
      otp_d   = '0;
      cnt_d   = '0;
    end else if (state_q == StWait) begin
      if (otp_ack) begin
        state_d = StIdle;
        otp_d   = '0;
        cnt_d   = '0;
      end
    end else if (press_clr) begin
      state_d = StIdle;
      otp_d   = '0;
      cnt_d   = '0;
    end else if (state_q == StSubmit) begin
      state_d = StWait;
    end else if (press_del) begin
      if (cnt_q != 3'd0) begin
        otp_d   = {4'h0, otp_q[W-1:4]};
        cnt_d   = cnt_dec;
        state_d = (cnt_dec == 3'd0) ? StIdle : StEntry;
      end
    end else if (press_submit) begin
      if (state_q == StFull && !busy) begin
        state_d = StSubmit;
      end else begin
        err_d = 1'b1;
      end
    end else if (press_load) begin
      if (state_q == StFull || din_s > 4'd9) begin
        err_d = 1'b1;
      end else begin
        otp_d   = {otp_q[W-5:0], din_s};
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == CntFull) ? StFull : StEntry;
      end
    end
  end

  assign valid_d = (state_d == StSubmit);
  assign full_d  = (cnt_d == CntFull);

  always_ff @(posedge clk_out_disp2 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= '0;
        din_sync_q[i] <= '0;
      end
      btn_prev_q <= '0;
      state_q    <= StIdle;
      otp_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i] <= btn_sync_d[i];
        din_sync_q[i] <= din_sync_d[i];
      end
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      otp_q      <= otp_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign user_otp   = otp_q;
  assign digit_cnt  = cnt_q;
  assign otp_valid  = valid_q;
  assign entry_full = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_otp_entry.sv
module tb_otp_entry;

  logic        clk_out_disp2 = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  din = '0;
  logic        btn_load = 1'b0, btn_del = 1'b0, btn_clr = 1'b0, btn_submit = 1'b0;
  logic        busy = 1'b0, lock = 1'b0, otp_ack = 1'b0;
  logic [15:0] user_otp;
  logic [2:0]  digit_cnt;
  logic        otp_valid, entry_full, err;

  int n_tests = 0;
  int n_fail  = 0;
  logic snap_err, snap_valid;

  otp_entry dut (
    .clk_out_disp2 (clk_out_disp2),
    .rstn          (rstn),
    .din           (din),
    .btn_load      (btn_load),
    .btn_del       (btn_del),
    .btn_clr       (btn_clr),
    .btn_submit    (btn_submit),
    .busy          (busy),
    .lock          (lock),
    .otp_ack       (otp_ack),
    .user_otp      (user_otp),
    .digit_cnt     (digit_cnt),
    .otp_valid     (otp_valid),
    .entry_full    (entry_full),
    .err           (err)
  );

  always #5 clk_out_disp2 = ~clk_out_disp2;

  // Raise the chosen buttons at a negedge, wait three rising edges (the action
  // lands on the third), snapshot the pulses, then release and let it settle.
  task automatic press(input logic c, input logic d, input logic s, input logic l);
    @(negedge clk_out_disp2);
    btn_clr = c; btn_del = d; btn_submit = s; btn_load = l;
    repeat (3) @(negedge clk_out_disp2);
    snap_err   = err;
    snap_valid = otp_valid;
    btn_clr = 1'b0; btn_del = 1'b0; btn_submit = 1'b0; btn_load = 1'b0;
    repeat (3) @(negedge clk_out_disp2);
  endtask

  task automatic load_digit(input logic [3:0] v);
    din = v;
    press(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({user_otp, digit_cnt, otp_valid, entry_full, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got otp=%h cnt=%0d v=%b f=%b e=%b required all 0",
               user_otp, digit_cnt, otp_valid, entry_full, err);
    end
    @(negedge clk_out_disp2);
    rstn = 1'b1;
    press(1'b0, 1'b1, 1'b0, 1'b0);  // del with nothing entered
    n_tests++;
    if (snap_err !== 1'b0 || digit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL del_empty: got err=%b cnt=%0d required err=0 cnt=0", snap_err, digit_cnt);
    end
  endtask

  task automatic test_load();
    // First digit with latency check: unchanged after two edges, updated at third.
    din = 4'd1;
    @(negedge clk_out_disp2);
    btn_load = 1'b1;
    repeat (2) @(negedge clk_out_disp2);
    n_tests++;
    if (digit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL load_early: got cnt=%0d required 0 before third edge", digit_cnt);
    end
    @(negedge clk_out_disp2);
    n_tests++;
    if (user_otp !== 16'h0001 || digit_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL load_latency: got otp=%h cnt=%0d required 0001/1", user_otp, digit_cnt);
    end
    btn_load = 1'b0;
    repeat (3) @(negedge clk_out_disp2);
    load_digit(4'd2);
    load_digit(4'd3);
    n_tests++;
    if (entry_full !== 1'b0) begin
      n_fail++;
      $display("FAIL full_at_3: got %b required 0", entry_full);
    end
    load_digit(4'd4);
    n_tests++;
    if (user_otp !== 16'h1234 || digit_cnt !== 3'd4 || entry_full !== 1'b1) begin
      n_fail++;
      $display("FAIL load_1234: got otp=%h cnt=%0d full=%b required 1234/4/1",
               user_otp, digit_cnt, entry_full);
    end
  endtask

  task automatic test_del_full();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (user_otp !== 16'h0123 || digit_cnt !== 3'd3 || entry_full !== 1'b0) begin
      n_fail++;
      $display("FAIL del: got otp=%h cnt=%0d full=%b required 0123/3/0",
               user_otp, digit_cnt, entry_full);
    end
    load_digit(4'd9);
    n_tests++;
    if (user_otp !== 16'h1239 || digit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL load_9: got otp=%h cnt=%0d required 1239/4", user_otp, digit_cnt);
    end
    load_digit(4'd5);
    n_tests++;
    if (snap_err !== 1'b1 || user_otp !== 16'h1239 || digit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL load_when_full: got err=%b otp=%h cnt=%0d required 1/1239/4",
               snap_err, user_otp, digit_cnt);
    end
  endtask

  task automatic test_errors();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (user_otp !== 16'h0000 || digit_cnt !== 3'd0 || entry_full !== 1'b0) begin
      n_fail++;
      $display("FAIL clr: got otp=%h cnt=%0d full=%b required 0/0/0",
               user_otp, digit_cnt, entry_full);
    end
    load_digit(4'd7);
    load_digit(4'hB);
    n_tests++;
    if (snap_err !== 1'b1 || user_otp !== 16'h0007 || digit_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL load_non_bcd: got err=%b otp=%h cnt=%0d required 1/0007/1",
               snap_err, user_otp, digit_cnt);
    end
    load_digit(4'd8);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (snap_err !== 1'b1 || snap_valid !== 1'b0 || user_otp !== 16'h0078) begin
      n_fail++;
      $display("FAIL submit_partial: got err=%b valid=%b otp=%h required 1/0/0078",
               snap_err, snap_valid, user_otp);
    end
  endtask

  task automatic test_submit();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    load_digit(4'd4); load_digit(4'd3); load_digit(4'd2); load_digit(4'd1);
    busy = 1'b1;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (snap_err !== 1'b1 || snap_valid !== 1'b0 || entry_full !== 1'b1) begin
      n_fail++;
      $display("FAIL submit_busy: got err=%b valid=%b full=%b required 1/0/1",
               snap_err, snap_valid, entry_full);
    end
    busy = 1'b0;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (snap_valid !== 1'b1 || snap_err !== 1'b0 || user_otp !== 16'h4321) begin
      n_fail++;
      $display("FAIL submit: got valid=%b err=%b otp=%h required 1/0/4321",
               snap_valid, snap_err, user_otp);
    end
    n_tests++;
    if (otp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_one_cycle: got %b required 0", otp_valid);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    load_digit(4'd6);
    n_tests++;
    if (snap_err !== 1'b0 || user_otp !== 16'h4321 || digit_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL wait_ignores: got err=%b otp=%h cnt=%0d required 0/4321/4",
               snap_err, user_otp, digit_cnt);
    end
    otp_ack = 1'b1;
    @(negedge clk_out_disp2);
    otp_ack = 1'b0;
    n_tests++;
    if (user_otp !== 16'h0000 || digit_cnt !== 3'd0 || entry_full !== 1'b0) begin
      n_fail++;
      $display("FAIL ack: got otp=%h cnt=%0d full=%b required 0/0/0",
               user_otp, digit_cnt, entry_full);
    end
  endtask

  task automatic test_back_to_back();
    load_digit(4'd2);
    load_digit(4'd3);
    din = 4'd6;
    press(1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (user_otp !== 16'h0000 || digit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_over_load: got otp=%h cnt=%0d required 0000/0", user_otp, digit_cnt);
    end
    din = 4'd5;
    @(negedge clk_out_disp2);
    btn_load = 1'b1;
    repeat (10) @(negedge clk_out_disp2);
    btn_load = 1'b0;
    repeat (3) @(negedge clk_out_disp2);
    n_tests++;
    if (user_otp !== 16'h0005 || digit_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL held_button: got otp=%h cnt=%0d required 0005/1", user_otp, digit_cnt);
    end
  endtask

  task automatic test_lock();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    load_digit(4'd1); load_digit(4'd2); load_digit(4'd3);
    @(negedge clk_out_disp2);
    lock = 1'b1;
    @(negedge clk_out_disp2);
    n_tests++;
    if (user_otp !== 16'h0000 || digit_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL lock_clear: got otp=%h cnt=%0d required 0000/0", user_otp, digit_cnt);
    end
    load_digit(4'd7);
    lock = 1'b0;
    repeat (3) @(negedge clk_out_disp2);
    n_tests++;
    if (user_otp !== 16'h0000 || digit_cnt !== 3'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_ignores: got otp=%h cnt=%0d err=%b required 0000/0/0",
               user_otp, digit_cnt, err);
    end
  endtask

  task automatic test_reset_wait();
    load_digit(4'd8); load_digit(4'd7); load_digit(4'd6); load_digit(4'd5);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (user_otp !== 16'h8765 || entry_full !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_wait: got otp=%h full=%b required 8765/1", user_otp, entry_full);
    end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({user_otp, digit_cnt, otp_valid, entry_full, err} !== 23'd0) begin
      n_fail++;
      $display("FAIL async_reset: got otp=%h cnt=%0d v=%b f=%b e=%b required all 0",
               user_otp, digit_cnt, otp_valid, entry_full, err);
    end
    @(negedge clk_out_disp2);
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_del_full();
    test_errors();
    test_submit();
    test_back_to_back();
    test_lock();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
